// File: rtl/forward_propagation.sv
// Single dense layer (5 inputs, 3 neurons) with Q2.7 weights, evaluated one MAC per cycle.
// Each neuron output is the saturated, ReLU-clipped accumulator in the range 0..511.
module forward_propagation (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        WE,
  input  logic [4:0]  WAddr,
  input  logic [9:0]  WData,
  input  logic        Start,
  input  logic [49:0] In,
  output logic        Busy,
  output logic        Done,
  output logic [29:0] Out1
);

  typedef enum logic [2:0] {StIdle, StLoad, StMac, StStore, StDone} state_e;

  state_e             state_q, state_d;
  logic signed [9:0]  param_q [18];
  logic signed [9:0]  param_d [18];
  logic signed [9:0]  x_q [5];
  logic signed [9:0]  x_d [5];
  logic [9:0]         res_q [3];
  logic [9:0]         res_d [3];
  logic signed [23:0] acc_q, acc_d;
  logic [2:0]         i_q, i_d;
  logic [1:0]         j_q, j_d;
  logic [29:0]        out_q, out_d;

  logic signed [9:0]  bias;
  logic signed [9:0]  weight;
  logic signed [19:0] prod;
  logic signed [23:0] shr;
  logic [9:0]         sat;

  assign Busy = (state_q == StLoad) || (state_q == StMac) || (state_q == StStore);
  assign Done = (state_q == StDone);
  assign Out1 = out_q;

  always_comb begin
    bias   = param_q[5'd15 + 5'(j_q)];
    weight = param_q[5'(j_q) * 5'd5 + 5'(i_q)];
    prod   = x_q[i_q] * weight;
    shr    = acc_q >>> 7;
    // Saturation and ReLU fold together: anything negative clips to 0.
    if (shr > 24'sd511) begin
      sat = 10'd511;
    end else if (shr < 24'sd0) begin
      sat = 10'd0;
    end else begin
      sat = shr[9:0];
    end
  end

  always_comb begin
    state_d = state_q;
    param_d = param_q;
    x_d     = x_q;
    res_d   = res_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    out_d   = out_q;

    if (WE && !Busy && (WAddr <= 5'd17)) begin
      param_d[WAddr] = WData;
    end

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          for (int k = 0; k < 5; k++) begin
            x_d[k] = In[10*k +: 10];
          end
          j_d     = 2'd0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        acc_d   = {{7{bias[9]}}, bias, 7'd0};
        i_d     = 3'd0;
        state_d = StMac;
      end
      StMac: begin
        acc_d = acc_q + {{4{prod[19]}}, prod};
        i_d   = i_q + 3'd1;
        if (i_q == 3'd4) begin
          state_d = StStore;
        end
      end
      StStore: begin
        res_d[j_q] = sat;
        if (j_q == 2'd2) begin
          out_d   = {sat, res_q[1], res_q[0]};
          state_d = StDone;
        end else begin
          j_d     = j_q + 2'd1;
          state_d = StLoad;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      out_q   <= '0;
      for (int k = 0; k < 18; k++) begin
        param_q[k] <= '0;
      end
      for (int k = 0; k < 5; k++) begin
        x_q[k] <= '0;
      end
      for (int k = 0; k < 3; k++) begin
        res_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
      out_q   <= out_d;
      param_q <= param_d;
      x_q     <= x_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: doc/forward_propagation.md
FORWARD_PROPAGATION -- requirements
Module: forward_propagation

Interface
REQ-001 Parameters: none; the layer is fixed at 5 inputs and 3 neurons, with 10-bit signed two's-complement data and Q2.7 weights/biases (128 = 1.0).
REQ-002 Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Rst  input  1  reset, synchronous, active-high.
REQ-004 WE  input  1  weight/bias write enable.
REQ-005 WAddr  input  5  parameter address: 5*j+i = weight w[j][i] (j 0..2 neuron, i 0..4 input); 15..17 = bias b[j].
REQ-006 WData  input  10  signed weight/bias value.
REQ-007 Start  input  1  single-cycle request to run one forward pass.
REQ-008 In  input  50  input vector; element i = In[10i+9:10i], signed.
REQ-009 Busy  output  1  high while a pass is in progress.
REQ-010 Done  output  1  one-cycle pulse when Out1 is valid.
REQ-011 Out1  output  30  neuron outputs; neuron j = Out1[10j+9:10j], signed, always in 0..511.

Function
REQ-012 Parameter storage is 18 x 10-bit registers; on an edge with WE=1, Busy=0 and WAddr<=17, register[WAddr] <= WData.
- WE with WAddr>=18 is ignored.
- WE while Busy=1 is ignored.
REQ-013 The FSM has states IDLE, LOAD, MAC, STORE and DONE.
REQ-014 IDLE: an edge with Start=1 registers In into a 5-entry input latch, clears neuron index j=0, and enters LOAD.
REQ-015 LOAD (1 cycle): acc <= sign-extended b[j] <<< 7; input index i <= 0; next state is MAC.
REQ-016 MAC (5 cycles): acc <= acc + x[i]*w[j][i] (20-bit signed product, 24-bit signed accumulator); i increments; leave to STORE after i=4.
REQ-017 STORE (1 cycle): compute r = acc >>> 7 (arithmetic shift).
- Saturate r to [-512, 511].
- Apply ReLU (negative -> 0).
- Write the result into an internal result register for neuron j.
- If j<2: j increments and next state is LOAD.
- Otherwise: copy all three results to Out1 and enter DONE.
REQ-018 DONE (1 cycle): Done=1, then return to IDLE.
REQ-019 Latency: the STORE edge for neuron 2 is the 21st edge after the Start-sampling edge; Done is high for exactly the cycle following it.
REQ-020 Busy=1 in LOAD, MAC and STORE; Busy=0 in IDLE and DONE.
REQ-021 Out1 changes only at the final STORE edge; it holds the previous pass value throughout a pass.
REQ-022 Start asserted while Busy=1 or in DONE is ignored and is not queued.
REQ-023 A change on In after the Start-sampling edge does not affect the running pass.
REQ-024 Start and a legal WE on the same IDLE edge: the write takes effect and the pass uses the new value (write precedes latch read).

Reset
REQ-025 When Rst=1 at an edge, regardless of state, the block returns to IDLE with:
- Busy=0, Done=0, Out1=0;
- acc, i, j, the result registers and the input latch cleared;
- all 18 weight/bias registers cleared to 0.
REQ-026 Rst has priority over Start and WE on the same edge.
REQ-027 A pass aborted by reset never produces Done.

Verification
REQ-028 Bias only: all weights 0, b={5,0,-3}, In all 0, Start -> after 21 edges Done pulses and Out1 = {5,0,0}.
REQ-029 Identity: w[j][j]=128, all other weights 0, biases 0, In={10,20,30,40,50}, Start -> Out1={10,20,30}; Busy high for exactly 21 cycles.
REQ-030 Saturation/ReLU:
- All weights 511 and In all 511 -> Out1 = {511,511,511}.
- All weights -128 with the same In -> Out1 = {0,0,0}.
REQ-031 Ignored events:
- Start pulsed 5 cycles into a pass -> a single Done at edge 21, with no second pass.
- WE to WAddr 20, or WE while Busy -> stored parameters unchanged (confirmed by a subsequent pass result).
REQ-032 Reset mid-pass: assert Rst at edge 10 of the identity pass -> Busy=0 next cycle, Done never asserts, Out1=0; a follow-up pass with all parameters cleared yields Out1={0,0,0}.
